// File: rtl/my_mem_responder_if.sv
// Byte-wide memory bus between an initiator (master) and the responder (slave).
interface my_mem_responder_if #(
    parameter int CNT_W = 16
);
    logic             write;
    logic             read;
    logic [7:0]       data_in;
    logic [15:0]      address;
    logic [8:0]       data_out;
    logic             data_valid;
    logic             busy;
    logic [CNT_W-1:0] collision_count;

    modport master (
        output write, read, data_in, address,
        input  data_out, data_valid, busy, collision_count
    );

    modport slave (
        input  write, read, data_in, address,
        output data_out, data_valid, busy, collision_count
    );
endinterface

// File: rtl/my_mem_responder.sv
// Parity-protected 9-bit word memory responder: clears itself after reset,
// then services single-cycle writes and registered reads, counting collisions.
module my_mem_responder #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    my_mem_responder_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  idx;
    logic [8:0]         mem [DEPTH];
    logic [8:0]         data_out;
    logic               data_valid;
    logic               busy;
    logic [CNT_W-1:0]   collision_count;

    assign idx = bus.address[ADDR_W-1:0];

    // High address bits alias; they are intentionally dropped.
    generate
        if (ADDR_W < 16) begin : g_alias
            logic unused_addr;
            assign unused_addr = ^bus.address[15:ADDR_W];
        end
    endgenerate

    // RAM port kept free of reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT)
                mem[ptr] <= 9'h000;
            else if (bus.write && !bus.read)
                mem[idx] <= {^bus.data_in, bus.data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= INIT;
            ptr             <= '0;
            busy            <= 1'b1;
            data_out        <= 9'h000;
            data_valid      <= 1'b0;
            collision_count <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.read && bus.write) begin
                        if (collision_count != '1)
                            collision_count <= collision_count + 1'b1;
                    end else if (bus.read) begin
                        data_out   <= mem[idx];
                        data_valid <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.data_out        = data_out;
    assign bus.data_valid      = data_valid;
    assign bus.busy            = busy;
    assign bus.collision_count = collision_count;
endmodule
